// File: rtl/seq_pkg.sv
// Shared definitions for the seq_* pattern blocks.
package seq_pkg;

  // Board default: one bit per second at 25 MHz so LEDs can follow the stream.
  localparam int SEQ_TICK_DIV = 25_000_000;

  // Serializer state encoding.
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Counter width for a modulus: $clog2 of the value, never below 1 bit.
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Handshake and serial-output bundle of the bit serializer.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             loop_mode;
  logic             ready;
  logic             busy;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output load, data_in, loop_mode,
    input  ready, busy, sout, sout_valid, done
  );

  modport slave (
    input  load, data_in, loop_mode,
    output ready, busy, sout, sout_valid, done
  );
endinterface

// File: rtl/seq_tick_gen.sv
// Bit-hold timer: down-counter with synchronous restart and terminal-count flag.
module seq_tick_gen
  import seq_pkg::*;
#(
  parameter int DIV = SEQ_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tc
);
  localparam int            TW  = cnt_w(DIV);
  localparam logic [TW-1:0] TOP = TW'(DIV - 1);

  logic [TW-1:0] tick;

  // Restart loads DIV-1; otherwise count down and park at zero (DIV=1 stays at 0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             tick <= '0;
    else if (restart)       tick <= TOP;
    else if (tick != '0)    tick <= tick - TW'(1);
  end

  assign tc = (tick == '0);
endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial pattern source: MSB first, each bit held TICK_DIV clocks,
// optional gapless repeat of the last loaded word.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = SEQ_TICK_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_bit_serializer_if.slave   bus
);
  localparam int            BW   = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  ser_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shadow;
  logic [BW-1:0]    bitcnt;
  logic             tick_tc;
  logic             take;
  logic             restart;

  assign take = (state == SER_IDLE) && bus.load;

  // Timer restarts whenever a new bit goes out: accept, shift, or loop reload.
  assign restart = take ||
                   ((state == SER_SHIFT) && tick_tc && ((bitcnt != '0) || bus.loop_mode));

  seq_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tc      (tick_tc)
  );

  assign bus.ready = (state == SER_IDLE);
  assign bus.busy  = (state != SER_IDLE);

  // FSM, shift/shadow registers, bit counter and registered serial outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= SER_IDLE;
      shreg          <= '0;
      shadow         <= '0;
      bitcnt         <= '0;
      bus.sout       <= 1'b0;
      bus.sout_valid <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.sout_valid <= 1'b0;
      bus.done       <= 1'b0;
      case (state)
        SER_IDLE: begin
          if (bus.load) begin
            shadow         <= bus.data_in;
            shreg          <= bus.data_in;
            bus.sout       <= bus.data_in[WIDTH-1];
            bus.sout_valid <= 1'b1;
            bitcnt         <= LAST;
            state          <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (tick_tc) begin
            if (bitcnt != '0) begin
              shreg          <= {shreg[WIDTH-2:0], 1'b0};
              bus.sout       <= shreg[WIDTH-2];
              bus.sout_valid <= 1'b1;
              bitcnt         <= bitcnt - BW'(1);
            end else if (bus.loop_mode) begin
              // Gapless repeat: the reload cycle itself emits the MSB.
              shreg          <= shadow;
              bus.sout       <= shadow[WIDTH-1];
              bus.sout_valid <= 1'b1;
              bitcnt         <= LAST;
            end else begin
              state    <= SER_IDLE;
              bus.sout <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: three configurations (W8/DIV1, W8/DIV3, W4/DIV1),
// per-bit scoreboard queues plus timing checks relative to the accept edge.
module tb_seq_bit_serializer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(8)) ifa ();
  seq_bit_serializer_if #(.WIDTH(8)) ifb ();
  seq_bit_serializer_if #(.WIDTH(4)) ifc ();

  seq_bit_serializer #(.WIDTH(8), .TICK_DIV(1)) ua (.clk(clk), .reset(rst_n), .bus(ifa));
  seq_bit_serializer #(.WIDTH(8), .TICK_DIV(3)) ub (.clk(clk), .reset(rst_n), .bus(ifb));
  seq_bit_serializer #(.WIDTH(4), .TICK_DIV(1)) uc (.clk(clk), .reset(rst_n), .bus(ifc));

  int checks = 0;
  int errors = 0;
  logic qa[$];
  logic qb[$];
  logic qc[$];
  int dca = 0, dcb = 0, dcc = 0;

  typedef struct {
    int         w;
    logic [7:0] word;
    int         div;
    int         width;
    int         exp_done;
    int         exp_pulses;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic extra(input string name);
    checks++;
    errors++;
    $display("FAIL %s: sout_valid with no bit expected", name);
  endtask

  // Scoreboards: every sout_valid pops one expected bit.
  always @(negedge clk) if (rst_n) begin
    if (ifa.done) dca++;
    if (ifa.sout_valid) begin
      if (qa.size() == 0) extra("a_extra_bit");
      else chk("a_bit", int'(ifa.sout), int'(qa.pop_front()));
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (ifb.done) dcb++;
    if (ifb.sout_valid) begin
      if (qb.size() == 0) extra("b_extra_bit");
      else chk("b_bit", int'(ifb.sout), int'(qb.pop_front()));
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (ifc.done) dcc++;
    if (ifc.sout_valid) begin
      if (qc.size() == 0) extra("c_extra_bit");
      else chk("c_bit", int'(ifc.sout), int'(qc.pop_front()));
    end
  end

  // {busy, ready, sout, sout_valid, done}
  function automatic logic [4:0] st(input int w);
    case (w)
      0:       return {ifa.busy, ifa.ready, ifa.sout, ifa.sout_valid, ifa.done};
      1:       return {ifb.busy, ifb.ready, ifb.sout, ifb.sout_valid, ifb.done};
      default: return {ifc.busy, ifc.ready, ifc.sout, ifc.sout_valid, ifc.done};
    endcase
  endfunction

  task automatic drv(input int w, input logic ld, input logic [7:0] d, input logic lm);
    case (w)
      0:       begin ifa.load = ld; ifa.data_in = d;      ifa.loop_mode = lm; end
      1:       begin ifb.load = ld; ifb.data_in = d;      ifb.loop_mode = lm; end
      default: begin ifc.load = ld; ifc.data_in = d[3:0]; ifc.loop_mode = lm; end
    endcase
  endtask

  task automatic push(input int w, input logic [7:0] d, input int width);
    for (int i = width - 1; i >= 0; i--) begin
      case (w)
        0:       qa.push_back(d[i]);
        1:       qb.push_back(d[i]);
        default: qc.push_back(d[i]);
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load one word; n counts edges after the accept edge (n=0 right after it).
  task automatic run_word(input int w, input logic [7:0] word, input int div, input int width,
                          output int done_at, output int pulses, output int gaps);
    logic [4:0] s;
    drv(w, 1'b1, word, 1'b0);
    push(w, word, width);
    step();
    drv(w, 1'b0, word, 1'b0);
    done_at = -1;
    pulses  = 0;
    gaps    = 0;
    for (int n = 0; n <= 200; n++) begin
      s = st(w);
      if (s[1]) begin
        if (n != pulses * div) gaps++;
        pulses++;
      end
      if (s[0]) begin
        done_at = n;
        chk("ready_at_done", int'(s[3]), 1);
        chk("sout_at_done", int'(s[2]), 0);
        break;
      end
      step();
    end
  endtask

  int         done_at, pulses, gaps, d1, s2, d2, z8, dc0;
  logic [4:0] s;

  initial begin
    tbl[0] = '{0, 8'b1101_0000, 1, 8, 8, 8};
    tbl[1] = '{0, 8'hA5,        1, 8, 8, 8};
    tbl[2] = '{0, 8'h01,        1, 8, 8, 8};
    tbl[3] = '{0, 8'h80,        1, 8, 8, 8};
    tbl[4] = '{1, 8'b1101_0000, 3, 8, 24, 8};
    tbl[5] = '{1, 8'h5A,        3, 8, 24, 8};
    tbl[6] = '{2, 8'h06,        1, 4, 4, 4};

    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) drv(w, 1'b0, 8'h00, 1'b0);
    #12;
    for (int w = 0; w < 3; w++) chk("reset_state", int'(st(w)), int'(5'b01000));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Table-driven words across all three configurations.
    foreach (tbl[i]) begin
      run_word(tbl[i].w, tbl[i].word, tbl[i].div, tbl[i].width, done_at, pulses, gaps);
      chk("tbl_done_edge", done_at, tbl[i].exp_done);
      chk("tbl_pulses", pulses, tbl[i].exp_pulses);
      chk("tbl_spacing", gaps, 0);
    end

    // load while busy is ignored: 8'hFF must never appear.
    drv(0, 1'b1, 8'h0F, 1'b0);
    push(0, 8'h0F, 8);
    step();
    drv(0, 1'b1, 8'hFF, 1'b0);
    repeat (4) step();
    drv(0, 1'b0, 8'hFF, 1'b0);
    done_at = -1;
    for (int n = 4; n <= 50; n++) begin
      if (st(0)[0]) begin done_at = n; break; end
      step();
    end
    chk("busy_load_done", done_at, 8);
    repeat (3) step();
    chk("busy_load_idle", int'(st(0)[3]), 1);

    // Back-to-back with load held high: exactly one sout=0 cycle between words.
    drv(0, 1'b1, 8'h96, 1'b0);
    push(0, 8'h96, 8);
    push(0, 8'h96, 8);
    step();
    d1 = -1; s2 = -1; d2 = -1; z8 = -1;
    for (int n = 0; n <= 60; n++) begin
      s = st(0);
      if (s[0] && d1 < 0) begin
        d1 = n;
        z8 = int'(s[2]);
      end else if (s[0]) begin
        d2 = n;
        break;
      end
      if (s[1] && d1 >= 0 && s2 < 0) begin
        s2 = n;
        drv(0, 1'b0, 8'h96, 1'b0);
      end
      step();
    end
    chk("b2b_done1", d1, 8);
    chk("b2b_gap_sout", z8, 0);
    chk("b2b_start2", s2, 9);
    chk("b2b_done2", d2, 17);

    // Loop mode: gapless repeats, then clear loop_mode during the fourth word.
    dc0 = dcc;
    drv(2, 1'b1, 8'h0B, 1'b1);
    for (int k = 0; k < 4; k++) push(2, 8'h0B, 4);
    step();
    drv(2, 1'b0, 8'h0B, 1'b1);
    done_at = -1; pulses = 0; gaps = 0;
    for (int n = 0; n <= 60; n++) begin
      s = st(2);
      if (s[1]) begin
        if (n != pulses) gaps++;
        pulses++;
      end
      if (s[0]) begin done_at = n; break; end
      if (n == 12) drv(2, 1'b0, 8'h0B, 1'b0);
      step();
    end
    chk("loop_done_edge", done_at, 16);
    chk("loop_pulses", pulses, 16);
    chk("loop_no_gap", gaps, 0);
    step();
    chk("loop_done_count", dcc - dc0, 1);

    // Async reset in the middle of bit 5 of 8'hFF (DIV=3): outputs clear before the next edge.
    drv(1, 1'b1, 8'hFF, 1'b0);
    push(1, 8'hFF, 8);
    step();
    drv(1, 1'b0, 8'hFF, 1'b0);
    repeat (16) step();
    chk("pre_reset_sout", int'(st(1)[2]), 1);
    dc0 = dcb;
    #2 rst_n = 1'b0;
    qb.delete();
    #1;
    chk("mid_reset_state", int'(st(1)), int'(5'b01000));
    step();
    rst_n = 1'b1;
    step();
    chk("mid_reset_no_done", dcb - dc0, 0);
    run_word(1, 8'hA5, 3, 8, done_at, pulses, gaps);
    chk("after_reset_done", done_at, 24);
    chk("after_reset_pulses", pulses, 8);

    step();
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
